axi_stream_combiner_2: RTL

AXI_STREAM_COMBINER_2 -- requirements
Module: axi_stream_combiner_2

---
 rtl/axi_stream_combiner_pkg.sv | 40 ++++
 rtl/axi_stream.sv | 16 +
 rtl/axi_stream_register_slice.sv | 56 +++++
 rtl/axi_stream_combiner_2.sv | 117 +++++++++++
 4 files changed

// File: rtl/axi_stream_combiner_pkg.sv
// Shared types for the two-input AXI-stream combiner: FSM states, grant codes
// and the round-robin arbitration rule.
package axi_stream_combiner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_1 = 2'd1,
        SERVE_2 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_1    = 2'b01;
    localparam logic [1:0] GRANT_2    = 2'b10;

    localparam logic SRC_1 = 1'b0;
    localparam logic SRC_2 = 1'b1;

    // Only valids are looked at, so ready never feeds back into the decision.
    function automatic state_t arbitrate(input logic valid_1,
                                         input logic valid_2,
                                         input logic last_served);
        if (valid_1 && valid_2)
            return (last_served == SRC_1) ? SERVE_2 : SERVE_1;
        else if (valid_1)
            return SERVE_1;
        else if (valid_2)
            return SERVE_2;
        else
            return IDLE;
    endfunction

    function automatic logic [1:0] grant_of(input state_t s);
        case (s)
            SERVE_1: return GRANT_1;
            SERVE_2: return GRANT_2;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axi_stream.sv
// AXI-stream bundle with data, dest, user, tlast and the valid/ready handshake.
interface axi_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (output data, dest, user, tlast, valid, input ready);
    modport slave  (input data, dest, user, tlast, valid, output ready);
endinterface

// File: rtl/axi_stream_register_slice.sv
// Single-entry output register: loads whenever it is empty or being drained,
// which also serves as the upstream ready.
module axi_stream_register_slice #(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [DEST_WIDTH-1:0] s_dest,
    input  logic [USER_WIDTH-1:0] s_user,
    input  logic                  s_tlast,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [DEST_WIDTH-1:0] m_dest,
    output logic [USER_WIDTH-1:0] m_user,
    output logic                  m_tlast,
    output logic                  m_valid,
    input  logic                  m_ready
);
    logic [DATA_WIDTH-1:0] data_p0;
    logic [DEST_WIDTH-1:0] dest_p0;
    logic [USER_WIDTH-1:0] user_p0;
    logic                  tlast_p0;
    logic                  vld_p0;

    assign s_ready = ~vld_p0 | m_ready;

    // Stage p0: output register
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_p0  <= '0;
            dest_p0  <= '0;
            user_p0  <= '0;
            tlast_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else if (s_ready) begin
            vld_p0 <= s_valid;
            if (s_valid) begin
                data_p0  <= s_data;
                dest_p0  <= s_dest;
                user_p0  <= s_user;
                tlast_p0 <= s_tlast;
            end
        end
    end

    assign m_data  = data_p0;
    assign m_dest  = dest_p0;
    assign m_user  = user_p0;
    assign m_tlast = tlast_p0;
    assign m_valid = vld_p0;

endmodule

// File: rtl/axi_stream_combiner_2.sv
// Two-input AXI-stream combiner: round-robin arbitration (per packet or per
// beat) in front of a single output register slice.
module axi_stream_combiner_2 #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 8,
    parameter int PACKET_MODE = 1
) (
    input  logic       clock,
    input  logic       reset,
    axi_stream.slave   stream_in_1,
    axi_stream.slave   stream_in_2,
    axi_stream.master  stream_out,
    output logic [1:0] grant
);
    import axi_stream_combiner_pkg::*;

    state_t state;
    logic   last_served;
    logic   le;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_tlast;
    logic                  sel_valid;

    logic   xfer_1, xfer_2, end_1, end_2;
    state_t arb_idle, arb_after_1, arb_after_2;

    always_comb begin
        sel_data  = stream_in_1.data;
        sel_dest  = stream_in_1.dest;
        sel_user  = stream_in_1.user;
        sel_tlast = stream_in_1.tlast;
        sel_valid = 1'b0;
        if (state == SERVE_1) begin
            sel_valid = stream_in_1.valid;
        end else if (state == SERVE_2) begin
            sel_data  = stream_in_2.data;
            sel_dest  = stream_in_2.dest;
            sel_user  = stream_in_2.user;
            sel_tlast = stream_in_2.tlast;
            sel_valid = stream_in_2.valid;
        end
    end

    // Gating with reset keeps both readies low before the first reset edge.
    assign stream_in_1.ready = reset & (state == SERVE_1) & le;
    assign stream_in_2.ready = reset & (state == SERVE_2) & le;

    assign xfer_1 = stream_in_1.valid & stream_in_1.ready;
    assign xfer_2 = stream_in_2.valid & stream_in_2.ready;
    assign end_1  = xfer_1 & ((PACKET_MODE == 0) | stream_in_1.tlast);
    assign end_2  = xfer_2 & ((PACKET_MODE == 0) | stream_in_2.tlast);

    assign arb_idle    = arbitrate(stream_in_1.valid, stream_in_2.valid, last_served);
    assign arb_after_1 = arbitrate(stream_in_1.valid, stream_in_2.valid, SRC_1);
    assign arb_after_2 = arbitrate(stream_in_1.valid, stream_in_2.valid, SRC_2);

    // Grant FSM; a finishing grant re-arbitrates on the same edge so packets
    // from alternating sources run back to back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            last_served <= SRC_2;
            grant       <= GRANT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    state <= arb_idle;
                    grant <= grant_of(arb_idle);
                end
                SERVE_1: begin
                    if (end_1) begin
                        last_served <= SRC_1;
                        state       <= arb_after_1;
                        grant       <= grant_of(arb_after_1);
                    end
                end
                SERVE_2: begin
                    if (end_2) begin
                        last_served <= SRC_2;
                        state       <= arb_after_2;
                        grant       <= grant_of(arb_after_2);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

    axi_stream_register_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEST_WIDTH(DEST_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_slice (
        .clock   (clock),
        .reset   (reset),
        .s_data  (sel_data),
        .s_dest  (sel_dest),
        .s_user  (sel_user),
        .s_tlast (sel_tlast),
        .s_valid (sel_valid),
        .s_ready (le),
        .m_data  (stream_out.data),
        .m_dest  (stream_out.dest),
        .m_user  (stream_out.user),
        .m_tlast (stream_out.tlast),
        .m_valid (stream_out.valid),
        .m_ready (stream_out.ready)
    );

endmodule
